// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, fetch FSM encoding and the bubble instruction.
package mips_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic {
    FETCH = 1'b0,
    DONE  = 1'b1
  } fetch_state_e;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset > load > increment > hold.
module pc_reg #(
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  // Increment keeps ADDR_W bits so the address wraps at the top of memory.
  always_ff @(posedge clk) begin
    if (rst)
      pc <= ADDR_W'(RESET_PC);
    else if (load)
      pc <= load_pc;
    else if (inc)
      pc <= pc + ONE;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, addresses instrMem and captures the IF/ID register.
module instr_fetch
  import mips_pkg::*;
#(
  parameter int ADDR_W   = mips_pkg::ADDR_W,
  parameter int DATA_W   = mips_pkg::DATA_W,
  parameter int RESET_PC = 0,
  parameter int PROG_LEN = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              done
);

  // One extra bit so PROG_LEN = 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] LEN     = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W:0] LAST_PC = (ADDR_W+1)'(PROG_LEN - 1);

  fetch_state_e      state, state_n;
  logic              capture, bubble, pc_inc;
  logic              pc_in_range, pc_is_last, tgt_in_range;
  logic [DATA_W-1:0] ir_p1;
  logic [ADDR_W-1:0] ir_pc_p1;
  logic              vld_p1;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (redirect),
    .load_pc(redirect_pc),
    .inc    (pc_inc),
    .pc     (pc)
  );

  assign imem_addr    = pc;
  assign pc_in_range  = {1'b0, pc} < LEN;
  assign pc_is_last   = {1'b0, pc} == LAST_PC;
  assign tgt_in_range = {1'b0, redirect_pc} < LEN;

  always_ff @(posedge clk) begin
    if (rst)
      state <= FETCH;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    bubble  = 1'b0;
    pc_inc  = 1'b0;
    if (redirect) begin
      state_n = tgt_in_range ? FETCH : DONE;
      bubble  = 1'b1;
    end else if (!stall) begin
      unique case (state)
        FETCH: begin
          // An out-of-range PC (only reachable from RESET_PC) stops without capturing.
          if (!pc_in_range) begin
            state_n = DONE;
            bubble  = 1'b1;
          end else begin
            capture = 1'b1;
            if (pc_is_last)
              state_n = DONE;
            else
              pc_inc = 1'b1;
          end
        end
        DONE:    bubble = 1'b1;
        default: state_n = FETCH;
      endcase
    end
  end

  // ---- IF/ID boundary (p1) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_p1    <= NOP;
      ir_pc_p1 <= '0;
      vld_p1   <= 1'b0;
    end else if (capture) begin
      ir_p1    <= imem_rd;
      ir_pc_p1 <= pc;
      vld_p1   <= 1'b1;
    end else if (bubble) begin
      vld_p1   <= 1'b0;
    end
  end

  assign ir       = ir_p1;
  assign ir_pc    = ir_pc_p1;
  assign ir_valid = vld_p1;
  assign done     = (state == DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instrMem; also exercises pc_reg wrap directly.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr, ir_pc, pc;
  logic [31:0] imem_rd, ir;
  logic        ir_valid, done;

  logic [7:0]  w_imem_addr, w_ir_pc, w_pc;
  logic [31:0] w_imem_rd, w_ir;
  logic        w_ir_valid, w_done;

  logic        pr_rst, pr_load, pr_inc;
  logic [7:0]  pr_load_pc, pr_pc;

  logic [31:0] mem [0:255];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rd   = mem[imem_addr];
  assign w_imem_rd = mem[w_imem_addr];

  instr_fetch #(.ADDR_W(8), .DATA_W(32), .RESET_PC(0), .PROG_LEN(5)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .pc(pc), .done(done)
  );

  instr_fetch #(.ADDR_W(8), .DATA_W(32), .RESET_PC(254), .PROG_LEN(256)) dut_wrap (
    .clk(clk), .rst(rst), .imem_addr(w_imem_addr), .imem_rd(w_imem_rd),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(8'd0),
    .ir(w_ir), .ir_pc(w_ir_pc), .ir_valid(w_ir_valid), .pc(w_pc), .done(w_done)
  );

  pc_reg #(.ADDR_W(8), .RESET_PC(0)) u_pc (
    .clk(clk), .rst(pr_rst), .load(pr_load), .load_pc(pr_load_pc), .inc(pr_inc), .pc(pr_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic [31:0] e_ir, input logic [7:0] e_irpc,
                        input logic e_vld, input logic [7:0] e_pc, input logic e_done);
    chk({tag, ".ir"},    ir,              e_ir);
    chk({tag, ".ir_pc"}, 32'(ir_pc),      32'(e_irpc));
    chk({tag, ".vld"},   32'(ir_valid),   32'(e_vld));
    chk({tag, ".pc"},    32'(pc),         32'(e_pc));
    chk({tag, ".done"},  32'(done),       32'(e_done));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] prog [0:4];

  initial begin
    prog[0] = 32'h20010003; prog[1] = 32'h20020009; prog[2] = 32'h00221020;
    prog[3] = 32'h00221824; prog[4] = 32'h00222025;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 + 32'(i);
    for (int i = 0; i < 5; i++) mem[i] = prog[i];

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 8'd0;
    pr_rst = 1'b1; pr_load = 1'b0; pr_inc = 1'b0; pr_load_pc = 8'd0;
    tick();
    tick();
    chk_if("reset", 32'h0, 8'd0, 1'b0, 8'd0, 1'b0);
    chk("reset.imem_addr", 32'(imem_addr), 32'd0);

    // Straight-line run
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_if($sformatf("run%0d", i), prog[i], 8'(i), 1'b1, (i == 4) ? 8'd4 : 8'(i + 1), i == 4);
    end
    tick();
    chk_if("run_end", prog[4], 8'd4, 1'b0, 8'd4, 1'b1);
    tick();
    chk_if("run_end2", prog[4], 8'd4, 1'b0, 8'd4, 1'b1);

    // Stall while ir_pc = 1
    do_reset();
    tick();
    tick();
    chk_if("pre_stall", prog[1], 8'd1, 1'b1, 8'd2, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_if($sformatf("stall%0d", k), prog[1], 8'd1, 1'b1, 8'd2, 1'b0);
    end
    stall = 1'b0;
    tick();
    chk_if("post_stall", prog[2], 8'd2, 1'b1, 8'd3, 1'b0);

    // Redirect while pc = 3
    redirect = 1'b1; redirect_pc = 8'd1;
    tick();
    chk_if("redir_bubble", prog[2], 8'd2, 1'b0, 8'd1, 1'b0);
    redirect = 1'b0;
    tick();
    chk_if("redir_target", prog[1], 8'd1, 1'b1, 8'd2, 1'b0);

    // Redirect and stall together
    redirect = 1'b1; stall = 1'b1; redirect_pc = 8'd0;
    tick();
    chk_if("rs_bubble", prog[1], 8'd1, 1'b0, 8'd0, 1'b0);
    redirect = 1'b0;
    tick();
    chk_if("rs_hold", prog[1], 8'd1, 1'b0, 8'd0, 1'b0);
    stall = 1'b0;
    tick();
    chk_if("rs_resume", prog[0], 8'd0, 1'b1, 8'd1, 1'b0);

    // Leave DONE via redirect, then an out-of-range target
    for (int i = 0; i < 5; i++) tick();
    chk_if("in_done", prog[4], 8'd4, 1'b0, 8'd4, 1'b1);
    redirect = 1'b1; redirect_pc = 8'd0;
    tick();
    chk_if("done_exit", prog[4], 8'd4, 1'b0, 8'd0, 1'b0);
    redirect = 1'b0;
    tick();
    chk_if("restart0", prog[0], 8'd0, 1'b1, 8'd1, 1'b0);
    redirect = 1'b1; redirect_pc = 8'd7;
    tick();
    chk_if("oor_redir", prog[0], 8'd0, 1'b0, 8'd7, 1'b1);
    redirect = 1'b0;
    tick();
    chk_if("oor_stay", prog[0], 8'd0, 1'b0, 8'd7, 1'b1);

    // Reset mid-run overrides pending redirect/stall
    do_reset();
    tick();
    tick();
    chk("mid.pc_before", 32'(pc), 32'd2);
    rst = 1'b1; redirect = 1'b1; redirect_pc = 8'd3; stall = 1'b1;
    tick();
    chk_if("mid_reset", 32'h0, 8'd0, 1'b0, 8'd0, 1'b0);
    rst = 1'b0; redirect = 1'b0; stall = 1'b0;

    // PROG_LEN=256, RESET_PC=254: stops at 255 without wrapping
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wrap.pc_reset", 32'(w_pc), 32'd254);
    tick();
    chk("wrap.pc1", 32'(w_pc), 32'd255);
    chk("wrap.ir1", w_ir, 32'hA5A500FE);
    chk("wrap.irpc1", 32'(w_ir_pc), 32'd254);
    chk("wrap.done1", 32'(w_done), 32'd0);
    tick();
    chk("wrap.pc2", 32'(w_pc), 32'd255);
    chk("wrap.ir2", w_ir, 32'hA5A500FF);
    chk("wrap.vld2", 32'(w_ir_valid), 32'd1);
    chk("wrap.done2", 32'(w_done), 32'd1);
    tick();
    chk("wrap.pc3", 32'(w_pc), 32'd255);
    chk("wrap.vld3", 32'(w_ir_valid), 32'd0);

    // Forced increment through pc_reg wraps 255 -> 0
    pr_rst = 1'b0; pr_load = 1'b1; pr_load_pc = 8'd255;
    tick();
    chk("pcreg.load", 32'(pr_pc), 32'd255);
    pr_load = 1'b0;
    tick();
    chk("pcreg.hold", 32'(pr_pc), 32'd255);
    pr_inc = 1'b1;
    tick();
    chk("pcreg.wrap", 32'(pr_pc), 32'd0);
    tick();
    chk("pcreg.inc", 32'(pr_pc), 32'd1);
    pr_inc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
